// File: rtl/stream_mux_arb.sv
// Registered N-channel stream mux with manual-select or round-robin arbitration.
// Define STREAM_MUX_ARB_LOCK_EN to add in_last and lock the round-robin grant per packet.
module stream_mux_arb #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef STREAM_MUX_ARB_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SELW-1:0] LAST_CHAN = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   CHAN_CNT  = (SELW+1)'(CHANNELS);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [SELW-1:0]  rot_idx   [CHANNELS];

  logic [WIDTH-1:0] data_reg;
  logic [SELW-1:0]  chan_reg;
  logic             valid_reg;
  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;

  logic             load_en;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [SELW-1:0]  rr_grant;
  logic             rr_found;
  logic             xfer;
  logic             ptr_adv;

`ifdef STREAM_MUX_ARB_LOCK_EN
  logic             lock_reg;
  logic [SELW-1:0]  lock_chan_reg;
`endif

  assign load_en = !valid_reg || out_ready;

  // rot_idx[k] is the channel examined k-th when scanning from ptr with wrap.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SELW:0] sum;
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign sum           = {1'b0, ptr_reg} + (SELW+1)'(gi);
      assign rot_idx[gi]   = (sum >= CHAN_CNT) ? SELW'(sum - CHAN_CNT) : sum[SELW-1:0];
      assign in_ready[gi]  = load_en && grant_valid && (grant == SELW'(gi));
    end
  endgenerate

  // Scan from the far end so the entry closest to ptr wins.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (in_valid[rot_idx[k]]) begin
        rr_found = 1'b1;
        rr_grant = rot_idx[k];
      end
    end
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (!rr_mode) begin
      grant       = sel;
      grant_valid = (int'(sel) < CHANNELS);
    end else begin
      grant       = rr_grant;
      grant_valid = rr_found;
`ifdef STREAM_MUX_ARB_LOCK_EN
      if (lock_reg) begin
        grant       = lock_chan_reg;
        grant_valid = 1'b1;
      end
`endif
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign ptr_next = (grant == LAST_CHAN) ? '0 : grant + 1'b1;

`ifdef STREAM_MUX_ARB_LOCK_EN
  // Mid-packet transfers keep ptr parked; it moves on only past the last word.
  assign ptr_adv = xfer && rr_mode && in_last[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg      <= 1'b0;
      lock_chan_reg <= '0;
    end else if (!rr_mode) begin
      lock_reg      <= 1'b0;
    end else if (xfer) begin
      lock_reg      <= !in_last[grant];
      lock_chan_reg <= grant;
    end
  end
`else
  assign ptr_adv = xfer && rr_mode;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      chan_reg  <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      if (xfer) begin
        data_reg  <= chan_data[grant];
        chan_reg  <= grant;
        valid_reg <= 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
      if (ptr_adv) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_chan  = chan_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed self-checking bench for stream_mux_arb: a 4-channel and a 3-channel instance.
module tb_stream_mux_arb;

  logic       clk;
  logic       rst_n;

  // 4-channel instance
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic       rr_mode;
  logic [1:0] out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;

  // 3-channel instance
  logic [5:0] in_data3;
  logic [2:0] in_valid3;
  logic [2:0] in_last3;
  logic [2:0] in_ready3;
  logic [1:0] sel3;
  logic       rr_mode3;
  logic [1:0] out_data3;
  logic [1:0] out_chan3;
  logic       out_valid3;
  logic       out_ready3;

  int errors = 0;
  int checks = 0;

  stream_mux_arb #(.WIDTH(2), .CHANNELS(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef STREAM_MUX_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  stream_mux_arb #(.WIDTH(2), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
`ifdef STREAM_MUX_ARB_LOCK_EN
    .in_last   (in_last3),
`endif
    .in_ready  (in_ready3),
    .sel       (sel3),
    .rr_mode   (rr_mode3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%b chan=%0d, want 0/00/0", out_valid, out_data, out_chan);
    end
    rst_n = 1'b1;
    sel   = 2'd3;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b11 || out_chan !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset_load: valid=%b data=%b chan=%0d, want 1/11/3", out_valid, out_data, out_chan);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%b chan=%0d, want 0/00/0", out_valid, out_data, out_chan);
    end
    step();
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_hold: valid=%b data=%b, want 0/00", out_valid, out_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_manual();
    logic [1:0] exp_data [4];
    exp_data[0] = 2'b01;
    exp_data[1] = 2'b10;
    exp_data[2] = 2'b00;
    exp_data[3] = 2'b11;
    rr_mode   = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 4'(1 << s)) begin
        errors++;
        $display("FAIL manual_ready[%0d]: in_ready=%b, want %b", s, in_ready, 4'(1 << s));
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[s] || out_chan !== 2'(s)) begin
        errors++;
        $display("FAIL manual_out[%0d]: valid=%b data=%b chan=%0d, want 1/%b/%0d",
                 s, out_valid, out_data, out_chan, exp_data[s], s);
      end
      $display("manual sel=%0d -> data=%b chan=%0d", s, out_data, out_chan);
    end
  endtask

  task automatic test_out_of_range();
    sel3 = 2'd1;
    step();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 2'b10 || out_chan3 !== 2'd1) begin
      errors++;
      $display("FAIL oor_preload: valid=%b data=%b chan=%0d, want 1/10/1", out_valid3, out_data3, out_chan3);
    end
    sel3 = 2'd3;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      errors++;
      $display("FAIL oor_ready: in_ready=%b, want 000", in_ready3);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 2'b10 || out_chan3 !== 2'd1) begin
        errors++;
        $display("FAIL oor_drain[%0d]: valid=%b data=%b chan=%0d, want 0/10/1",
                 c, out_valid3, out_data3, out_chan3);
      end
    end
    $display("out_of_range sel=3 -> valid=%b data=%b", out_valid3, out_data3);
  endtask

  task automatic test_backpressure();
    sel       = 2'd1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    sel       = 2'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || out_data !== 2'b10 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d]: in_ready=%b data=%b valid=%b, want 0000/10/1",
                 c, in_ready, out_data, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b, want 0100", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b00 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL drain_and_load: valid=%b data=%b chan=%0d, want 1/00/2", out_valid, out_data, out_chan);
    end
    sel = 2'd3;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back: valid=%b data=%b, want 1/11", out_valid, out_data);
    end
    $display("backpressure released -> data=%b valid=%b", out_data, out_valid);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_all [8];
    logic [1:0] exp_odd [4];
    exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
    rr_mode   = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== exp_all[c]) begin
        errors++;
        $display("FAIL rr_all[%0d]: valid=%b chan=%0d, want 1/%0d", c, out_valid, out_chan, exp_all[c]);
      end
      $display("rr all-valid grant %0d -> chan=%0d", c, out_chan);
    end
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== exp_odd[c]) begin
        errors++;
        $display("FAIL rr_odd[%0d]: valid=%b chan=%0d, want 1/%0d", c, out_valid, out_chan, exp_odd[c]);
      end
      $display("rr ch1/ch3 grant %0d -> chan=%0d", c, out_chan);
    end
  endtask

  task automatic test_ptr_hold();
    rr_mode  = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_chan !== 2'd2 || out_data !== 2'b00) begin
        errors++;
        $display("FAIL manual_interlude[%0d]: chan=%0d data=%b, want 2/00", c, out_chan, out_data);
      end
    end
    rr_mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ptr_hold_ready: in_ready=%b, want 0001", in_ready);
    end
    step();
    checks++;
    if (out_chan !== 2'd0 || out_data !== 2'b01) begin
      errors++;
      $display("FAIL ptr_hold_grant: chan=%0d data=%b, want 0/01", out_chan, out_data);
    end
    $display("ptr hold -> rr resumes at chan=%0d", out_chan);
  endtask

`ifdef STREAM_MUX_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_chan [4];
    exp_chan = '{2'd1, 2'd1, 2'd1, 2'd2};
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    step();
    checks++;
    if (out_chan !== exp_chan[0]) begin
      errors++;
      $display("FAIL lock[0]: chan=%0d, want %0d", out_chan, exp_chan[0]);
    end
    in_valid = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_ready: in_ready=%b, want 0010", in_ready);
    end
    step();
    checks++;
    if (out_chan !== exp_chan[1]) begin
      errors++;
      $display("FAIL lock[1]: chan=%0d, want %0d", out_chan, exp_chan[1]);
    end
    in_last = 4'b1111;
    for (int c = 2; c < 4; c++) begin
      step();
      checks++;
      if (out_chan !== exp_chan[c]) begin
        errors++;
        $display("FAIL lock[%0d]: chan=%0d, want %0d", c, out_chan, exp_chan[c]);
      end
    end
    $display("lock packet on ch1 then chan=%0d", out_chan);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_data    = 8'b11_00_10_01;
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    sel        = 2'd0;
    rr_mode    = 1'b0;
    out_ready  = 1'b0;
    in_data3   = 6'b00_10_01;
    in_valid3  = 3'b111;
    in_last3   = 3'b111;
    sel3       = 2'd0;
    rr_mode3   = 1'b0;
    out_ready3 = 1'b1;

    test_reset();
    test_manual();
    test_out_of_range();
    test_backpressure();
    test_round_robin();
    test_ptr_hold();
`ifdef STREAM_MUX_ARB_LOCK_EN
    test_lock();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
